// File: rtl/swd_host.sv
`default_nettype none
// ============================================================================
// Module      : swd_host
// Description : Serial Wire Debug host engine. Issues one SWD packet (DP/AP
//               read or write) or a line-reset sequence per command, generates
//               SWCLK from the system clock, and captures ACK, read data and
//               read-data parity status.
// Revision    : 1.0 - initial release
// ============================================================================
module swd_host #(
  parameter int CLK_DIV = 4,  // half-period of o_swclk in i_clk cycles (>=2)
  parameter int TURN    = 1   // turnaround length in bit periods (1..4)
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_line_reset,
  input  logic        i_apndp,
  input  logic        i_rnw,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [2:0]  o_ack,
  output logic [31:0] o_rdata,
  output logic        o_perr,
  output logic        o_swclk,
  output logic        o_swdio_out,
  output logic        o_swdio_oe,
  input  logic        i_swdio_in
);

  localparam int PW = $clog2(2 * CLK_DIV);
  localparam logic [PW-1:0] PH_LAST = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HIGH = PW'(CLK_DIV);
  localparam logic [5:0]    TRN_LAST = 6'(TURN - 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_REQ      = 4'd1;
  localparam logic [3:0] S_TRN1     = 4'd2;
  localparam logic [3:0] S_ACK      = 4'd3;
  localparam logic [3:0] S_RDATA    = 4'd4;
  localparam logic [3:0] S_TRN2     = 4'd5;
  localparam logic [3:0] S_WDATA    = 4'd6;
  localparam logic [3:0] S_IDLEBITS = 4'd7;
  localparam logic [3:0] S_LRST     = 4'd8;

  logic [3:0]    state;
  logic [3:0]    next_state;
  logic [PW-1:0] phase;          // position inside the current bit period
  logic [5:0]    bit_cnt;        // bit index inside the current state
  logic [5:0]    field_last;     // index of the last bit of the current state
  logic          accept;
  logic          bit_end;
  logic          last_bit;
  logic [2:0]    ack_now;        // ACK including the bit sampled this cycle

  logic [7:0]    req_bits;
  logic          cmd_rnw;
  logic [31:0]   wdata_q;
  logic [2:0]    ack_sh;
  logic          ack_ok;
  logic [31:0]   rdata_sh;
  logic          perr_sh;
  logic [2:0]    ack_q;
  logic [31:0]   rdata_q;
  logic          perr_q;
  logic          done_q;

  assign accept  = (state == S_IDLE) && (i_start || i_line_reset);
  assign bit_end = (state != S_IDLE) && (phase == PH_LAST);
  assign last_bit = bit_end && (bit_cnt == field_last);
  assign ack_now = {i_swdio_in, ack_sh[2:1]};

  // Length of each state's field, expressed as its final bit index
  always_comb begin
    field_last = 6'd0;
    case (state)
      S_REQ:      field_last = 6'd7;
      S_TRN1:     field_last = TRN_LAST;
      S_ACK:      field_last = 6'd2;
      S_RDATA:    field_last = 6'd32;
      S_TRN2:     field_last = TRN_LAST;
      S_WDATA:    field_last = 6'd32;
      S_IDLEBITS: field_last = 6'd7;
      S_LRST:     field_last = 6'd63;
      default:    field_last = 6'd0;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next-state logic: states only advance at the end of their final bit
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (i_line_reset)  next_state = S_LRST;
        else if (i_start)  next_state = S_REQ;
      end
      S_REQ:   if (last_bit) next_state = S_TRN1;
      S_TRN1:  if (last_bit) next_state = S_ACK;
      S_ACK: begin
        if (last_bit) begin
          if ((ack_now == 3'b001) && cmd_rnw) next_state = S_RDATA;
          else                                next_state = S_TRN2;
        end
      end
      S_RDATA: if (last_bit) next_state = S_TRN2;
      S_TRN2: begin
        if (last_bit) begin
          if (!ack_ok)      next_state = S_IDLE;
          else if (cmd_rnw) next_state = S_IDLEBITS;
          else              next_state = S_WDATA;
        end
      end
      S_WDATA:    if (last_bit) next_state = S_IDLEBITS;
      S_IDLEBITS: if (last_bit) next_state = S_IDLE;
      S_LRST:     if (last_bit) next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // Bit timing, command latch, sampling and result registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      phase    <= '0;
      bit_cnt  <= 6'd0;
      req_bits <= 8'd0;
      cmd_rnw  <= 1'b0;
      wdata_q  <= 32'd0;
      ack_sh   <= 3'd0;
      ack_ok   <= 1'b0;
      rdata_sh <= 32'd0;
      perr_sh  <= 1'b0;
      ack_q    <= 3'd0;
      rdata_q  <= 32'd0;
      perr_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state != S_IDLE) && (next_state == S_IDLE);
      if (accept) begin
        phase   <= '0;
        bit_cnt <= 6'd0;
        if (!i_line_reset) begin
          // Request: start, APnDP, RnW, A2, A3, parity, stop, park (LSB first)
          req_bits <= {1'b1, 1'b0, i_apndp ^ i_rnw ^ i_addr[0] ^ i_addr[1],
                       i_addr[1], i_addr[0], i_rnw, i_apndp, 1'b1};
          cmd_rnw  <= i_rnw;
          wdata_q  <= i_wdata;
        end
      end else if (state != S_IDLE) begin
        phase <= bit_end ? '0 : phase + PW'(1);
        if (bit_end) begin
          bit_cnt <= last_bit ? 6'd0 : bit_cnt + 6'd1;
          case (state)
            S_ACK: begin
              ack_sh <= ack_now;
              if (last_bit) ack_ok <= (ack_now == 3'b001);
            end
            S_RDATA: begin
              if (bit_cnt < 6'd32) rdata_sh <= {i_swdio_in, rdata_sh[31:1]};
              else                 perr_sh  <= (^rdata_sh) != i_swdio_in;
            end
            default: ;
          endcase
        end
        // Results are published together with the done pulse
        if (last_bit && (next_state == S_IDLE)) begin
          if (state == S_LRST) begin
            ack_q  <= 3'd0;
            perr_q <= 1'b0;
          end else begin
            ack_q <= ack_sh;
            if (ack_ok && cmd_rnw) begin
              rdata_q <= rdata_sh;
              perr_q  <= perr_sh;
            end else begin
              perr_q <= 1'b0;
            end
          end
        end
      end
    end
  end

  // Wire outputs decoded from the current state and bit position
  always_comb begin
    o_swdio_out = 1'b0;
    o_swdio_oe  = 1'b1;
    o_swclk     = (state != S_IDLE) && (phase >= PH_HIGH);
    case (state)
      S_REQ:   o_swdio_out = req_bits[bit_cnt[2:0]];
      S_TRN1, S_ACK, S_RDATA, S_TRN2: o_swdio_oe = 1'b0;
      S_WDATA: o_swdio_out = bit_cnt[5] ? (^wdata_q) : wdata_q[bit_cnt[4:0]];
      S_LRST:  o_swdio_out = (bit_cnt < 6'd56);
      default: ;
    endcase
  end

  assign o_busy  = (state != S_IDLE);
  assign o_done  = done_q;
  assign o_ack   = ack_q;
  assign o_rdata = rdata_q;
  assign o_perr  = perr_q;

endmodule
`default_nettype wire
